// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types for the front-end PC-select controller: pcmux select encoding,
// BHT counter states, BTB entry layout and the counter update helper.
package pcmux_pkg;
  typedef enum logic [2:0] {
    pc_plus4   = 3'd0,
    br_predict = 3'd1,
    alu_out    = 3'd2,
    alu_mod2   = 3'd3,
    br_en      = 3'd4
  } pcmux_sel_t;
endpackage

package bp_types;
  localparam int unsigned BP_IDX_W      = 5;
  // Tag field sized for the smallest legal index; unused upper bits stay zero
  localparam int unsigned BTB_TAG_MAX_W = 30;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_t;

  typedef struct packed {
    logic                     valid;
    logic                     uncond;
    logic [BTB_TAG_MAX_W-1:0] tag;
    logic [31:0]              target;
  } btb_entry_t;

  function automatic bp_cnt_t bp_cnt_next(input bp_cnt_t cnt, input logic taken);
    bp_cnt_t nxt;
    nxt = cnt;
    if (taken && cnt != ST) nxt = bp_cnt_t'(2'(cnt + 2'd1));
    else if (!taken && cnt != SNT) nxt = bp_cnt_t'(2'(cnt - 2'd1));
    return nxt;
  endfunction
endpackage

// File: rtl/branch_predict_ctrl_if.sv
// IF/EX-side bus of the PC-select controller. BP_PERF_CNT_EN adds the
// perf_br_cnt / perf_misp_cnt counter outputs.
interface branch_predict_ctrl_if;
  logic [31:0]             if_pc;
  pcmux_pkg::pcmux_sel_t   pcmux_sel;
  logic                    pred_taken;
  logic [31:0]             pred_target;
  logic [31:0]             redirect_pc;
  logic                    flush;
  logic                    ex_valid;
  logic                    ex_stall;
  logic                    ex_is_br;
  logic                    ex_is_jal;
  logic                    ex_is_jalr;
  logic [31:0]             ex_pc;
  logic                    ex_br_en;
  logic [31:0]             ex_target;
  logic                    ex_pred_taken;
  logic [31:0]             ex_pred_target;
`ifdef BP_PERF_CNT_EN
  logic [31:0]             perf_br_cnt;
  logic [31:0]             perf_misp_cnt;

  modport master (
    output if_pc, ex_valid, ex_stall, ex_is_br, ex_is_jal, ex_is_jalr, ex_pc,
           ex_br_en, ex_target, ex_pred_taken, ex_pred_target,
    input  pcmux_sel, pred_taken, pred_target, redirect_pc, flush,
           perf_br_cnt, perf_misp_cnt
  );
  modport slave (
    input  if_pc, ex_valid, ex_stall, ex_is_br, ex_is_jal, ex_is_jalr, ex_pc,
           ex_br_en, ex_target, ex_pred_taken, ex_pred_target,
    output pcmux_sel, pred_taken, pred_target, redirect_pc, flush,
           perf_br_cnt, perf_misp_cnt
  );
`else
  modport master (
    output if_pc, ex_valid, ex_stall, ex_is_br, ex_is_jal, ex_is_jalr, ex_pc,
           ex_br_en, ex_target, ex_pred_taken, ex_pred_target,
    input  pcmux_sel, pred_taken, pred_target, redirect_pc, flush
  );
  modport slave (
    input  if_pc, ex_valid, ex_stall, ex_is_br, ex_is_jal, ex_is_jalr, ex_pc,
           ex_br_en, ex_target, ex_pred_taken, ex_pred_target,
    output pcmux_sel, pred_taken, pred_target, redirect_pc, flush
  );
`endif
endinterface

// File: rtl/branch_predict_ctrl_btb.sv
// Tagged BTB: flop array with asynchronous read, tag compare and one
// clocked write port. Reset clears only the valid bits.
module bp_btb
  import bp_types::*;
#(
  parameter int unsigned IDX_W = BP_IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] rd_pc,
  output logic        rd_hit,
  output logic        rd_uncond,
  output logic [31:0] rd_target,
  input  logic        wr_en,
  input  logic [31:2] wr_pc,
  input  logic        wr_uncond,
  input  logic [31:0] wr_target
);
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  btb_entry_t               mem [DEPTH];
  logic [IDX_W-1:0]         rd_idx;
  logic [IDX_W-1:0]         wr_idx;
  logic [BTB_TAG_MAX_W-1:0] rd_tag;
  logic [BTB_TAG_MAX_W-1:0] wr_tag;
  btb_entry_t               rd_entry;

  assign rd_idx   = rd_pc[IDX_W+1:2];
  assign wr_idx   = wr_pc[IDX_W+1:2];
  assign rd_tag   = BTB_TAG_MAX_W'(rd_pc[31 -: TAG_W]);
  assign wr_tag   = BTB_TAG_MAX_W'(wr_pc[31 -: TAG_W]);
  assign rd_entry = mem[rd_idx];

  assign rd_hit    = rd_entry.valid && (rd_entry.tag == rd_tag);
  assign rd_uncond = rd_entry.uncond;
  assign rd_target = rd_entry.target;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i].valid <= 1'b0;
    end else if (wr_en) begin
      mem[wr_idx] <= '{valid: 1'b1, uncond: wr_uncond, tag: wr_tag, target: wr_target};
    end
  end
endmodule

// File: rtl/branch_predict_ctrl.sv
// Front-end PC-select controller: BHT + BTB prediction in IF, resolve and
// training from EX. Optional BP_PERF_CNT_EN adds saturating perf counters.
module branch_predict_ctrl
  import bp_types::*;
  import pcmux_pkg::*;
#(
  parameter int unsigned IDX_W = BP_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_predict_ctrl_if.slave bus
);
  localparam int unsigned DEPTH = 1 << IDX_W;

  bp_cnt_t          bht [DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  bp_cnt_t          if_cnt;
  logic             btb_hit;
  logic             btb_uncond;
  logic [31:0]      btb_target;

  logic             act;
  logic             is_cond;
  logic             misp;
  logic             actual_taken;
  logic             btb_wr;

  pcmux_sel_t       sel;
  logic             flush;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic [31:0]      redirect_pc;

  assign if_idx = bus.if_pc[IDX_W+1:2];
  assign ex_idx = bus.ex_pc[IDX_W+1:2];
  assign if_cnt = bht[if_idx];

  bp_btb #(.IDX_W(IDX_W)) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (bus.if_pc[31:2]),
    .rd_hit    (btb_hit),
    .rd_uncond (btb_uncond),
    .rd_target (btb_target),
    .wr_en     (btb_wr),
    .wr_pc     (bus.ex_pc[31:2]),
    .wr_uncond (bus.ex_is_jal),
    .wr_target (bus.ex_target)
  );

  assign act     = bus.ex_valid && !bus.ex_stall &&
                   (bus.ex_is_br || bus.ex_is_jal || bus.ex_is_jalr);
  assign is_cond = bus.ex_is_br && !bus.ex_is_jal && !bus.ex_is_jalr;
  assign btb_wr  = act && !bus.ex_is_jalr &&
                   (bus.ex_is_jal || (bus.ex_is_br && bus.ex_br_en));

  // Resolve: JALR always redirects, JAL must be predicted taken to the right target
  always_comb begin
    misp         = 1'b0;
    actual_taken = 1'b0;
    if (bus.ex_is_jalr) begin
      actual_taken = 1'b1;
      misp         = 1'b1;
    end else if (bus.ex_is_jal) begin
      actual_taken = 1'b1;
      misp         = !bus.ex_pred_taken || (bus.ex_pred_target != bus.ex_target);
    end else if (bus.ex_is_br) begin
      actual_taken = bus.ex_br_en;
      misp         = (bus.ex_br_en != bus.ex_pred_taken) ||
                     (bus.ex_br_en && bus.ex_pred_taken &&
                      (bus.ex_pred_target != bus.ex_target));
    end
  end

  // PC select: EX correction outranks the IF prediction; reset forces idle outputs
  always_comb begin
    sel         = pc_plus4;
    flush       = 1'b0;
    pred_taken  = 1'b0;
    pred_target = 32'd0;
    redirect_pc = 32'd0;
    if (!rst) begin
      pred_taken  = btb_hit && (btb_uncond || if_cnt[1]);
      pred_target = btb_hit ? btb_target : bus.if_pc + 32'd4;
      if (act) redirect_pc = bus.ex_pc + 32'd4;
      if (act && bus.ex_is_jalr) begin
        sel   = alu_mod2;
        flush = 1'b1;
      end else if (act && misp && actual_taken) begin
        sel   = alu_out;
        flush = 1'b1;
      end else if (act && misp) begin
        sel   = br_en;
        flush = 1'b1;
      end else if (pred_taken) begin
        sel = br_predict;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) bht[i] <= WNT;
    end else if (act && is_cond) begin
      bht[ex_idx] <= bp_cnt_next(bht[ex_idx], bus.ex_br_en);
    end
  end

  assign bus.pcmux_sel   = sel;
  assign bus.flush       = flush;
  assign bus.pred_taken  = pred_taken;
  assign bus.pred_target = pred_target;
  assign bus.redirect_pc = redirect_pc;

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_br_q;
  logic [31:0] perf_misp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_q   <= 32'd0;
      perf_misp_q <= 32'd0;
    end else begin
      if (act && perf_br_q != 32'hFFFF_FFFF) perf_br_q <= perf_br_q + 32'd1;
      if (flush && perf_misp_q != 32'hFFFF_FFFF) perf_misp_q <= perf_misp_q + 32'd1;
    end
  end

  assign bus.perf_br_cnt   = perf_br_q;
  assign bus.perf_misp_cnt = perf_misp_q;
`endif
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: each driven cycle pushes its
// expected pcmux outputs, the negedge monitor pops and compares them.
module tb_branch_predict_ctrl;
  import pcmux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predict_ctrl_if bus ();
  branch_predict_ctrl #(.IDX_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned id;
    pcmux_sel_t  sel;
    logic        flush;
    logic        pt;
    logic [31:0] ptgt;
    logic [31:0] rpc;
  } exp_t;

  typedef struct {
    logic        valid, stall, br, jal, jalr, en, pt;
    logic [31:0] pc, tgt, ptgt;
  } ex_t;

  exp_t        sb[$];
  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  int unsigned step_id      = 0;
  ex_t         tmp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  function automatic ex_t no_ex();
    ex_t e;
    e = '{valid: 1'b0, stall: 1'b0, br: 1'b0, jal: 1'b0, jalr: 1'b0, en: 1'b0,
          pt: 1'b0, pc: 32'd0, tgt: 32'd0, ptgt: 32'd0};
    return e;
  endfunction

  function automatic ex_t mk_br(input logic [31:0] pc, input logic en, input logic [31:0] tgt,
                                input logic pt, input logic [31:0] ptgt, input logic stall);
    ex_t e;
    e = no_ex();
    e.valid = 1'b1; e.br = 1'b1; e.stall = stall;
    e.pc = pc; e.en = en; e.tgt = tgt; e.pt = pt; e.ptgt = ptgt;
    return e;
  endfunction

  function automatic ex_t mk_jal(input logic [31:0] pc, input logic [31:0] tgt,
                                 input logic pt, input logic [31:0] ptgt);
    ex_t e;
    e = no_ex();
    e.valid = 1'b1; e.jal = 1'b1;
    e.pc = pc; e.tgt = tgt; e.pt = pt; e.ptgt = ptgt;
    return e;
  endfunction

  function automatic ex_t mk_jalr(input logic [31:0] pc, input logic [31:0] tgt, input logic stall);
    ex_t e;
    e = no_ex();
    e.valid = 1'b1; e.jalr = 1'b1; e.stall = stall;
    e.pc = pc; e.tgt = tgt; e.ptgt = pc + 32'd4;
    return e;
  endfunction

  // Drive one cycle just after the edge and queue what that cycle must show
  task automatic step(input logic r, input logic [31:0] ifpc, input ex_t ex,
                      input pcmux_sel_t sel, input logic fl, input logic pt,
                      input logic [31:0] ptgt, input logic [31:0] rpc);
    exp_t x;
    @(posedge clk);
    #1;
    rst                = r;
    bus.if_pc          = ifpc;
    bus.ex_valid       = ex.valid;
    bus.ex_stall       = ex.stall;
    bus.ex_is_br       = ex.br;
    bus.ex_is_jal      = ex.jal;
    bus.ex_is_jalr     = ex.jalr;
    bus.ex_pc          = ex.pc;
    bus.ex_br_en       = ex.en;
    bus.ex_target      = ex.tgt;
    bus.ex_pred_taken  = ex.pt;
    bus.ex_pred_target = ex.ptgt;
    x = '{id: step_id, sel: sel, flush: fl, pt: pt, ptgt: ptgt, rpc: rpc};
    sb.push_back(x);
    step_id++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq($sformatf("s%0d.sel", e.id),   32'(bus.pcmux_sel),   32'(e.sel));
      check_eq($sformatf("s%0d.flush", e.id), 32'(bus.flush),       32'(e.flush));
      check_eq($sformatf("s%0d.pt", e.id),    32'(bus.pred_taken),  32'(e.pt));
      check_eq($sformatf("s%0d.ptgt", e.id),  bus.pred_target,      e.ptgt);
      check_eq($sformatf("s%0d.rpc", e.id),   bus.redirect_pc,      e.rpc);
    end
  end

  initial begin
    rst = 1'b1;
    bus.if_pc = 32'h60;
    bus.ex_valid = 1'b0; bus.ex_stall = 1'b0; bus.ex_is_br = 1'b0;
    bus.ex_is_jal = 1'b0; bus.ex_is_jalr = 1'b0; bus.ex_pc = 32'd0;
    bus.ex_br_en = 1'b0; bus.ex_target = 32'd0; bus.ex_pred_taken = 1'b0;
    bus.ex_pred_target = 32'd0;

    // reset and first fetch
    step(1, 32'h60, no_ex(), pc_plus4, 0, 0, 32'h0, 32'h0);
    step(1, 32'h60, no_ex(), pc_plus4, 0, 0, 32'h0, 32'h0);
    step(0, 32'h60, no_ex(), pc_plus4, 0, 0, 32'h64, 32'h0);
    // taken branch at 0x100 mispredicted; IF same index still sees the old miss
    step(0, 32'h100, mk_br(32'h100, 1, 32'h140, 0, 32'h104, 0), alu_out, 1, 0, 32'h104, 32'h104);
    step(0, 32'h100, no_ex(), br_predict, 0, 1, 32'h140, 32'h0);
    // two not-taken resolves: WT -> WNT -> SNT, BTB still hits
    step(0, 32'h100, mk_br(32'h100, 0, 32'h140, 1, 32'h140, 0), br_en, 1, 1, 32'h140, 32'h104);
    step(0, 32'h100, mk_br(32'h100, 0, 32'h140, 1, 32'h140, 0), br_en, 1, 0, 32'h140, 32'h104);
    step(0, 32'h100, no_ex(), pc_plus4, 0, 0, 32'h140, 32'h0);
    // SNT saturates, then one taken only reaches WNT
    step(0, 32'h100, mk_br(32'h100, 0, 32'h140, 0, 32'h104, 0), pc_plus4, 0, 0, 32'h140, 32'h104);
    step(0, 32'h100, mk_br(32'h100, 1, 32'h140, 0, 32'h104, 0), alu_out, 1, 0, 32'h140, 32'h104);
    step(0, 32'h100, no_ex(), pc_plus4, 0, 0, 32'h140, 32'h0);
    // taken with wrong predicted target, then correctly predicted
    step(0, 32'h100, mk_br(32'h100, 1, 32'h140, 1, 32'h150, 0), alu_out, 1, 0, 32'h140, 32'h104);
    step(0, 32'h100, mk_br(32'h100, 1, 32'h140, 1, 32'h140, 0), br_predict, 0, 1, 32'h140, 32'h104);
    // aliasing index with different tag misses
    step(0, 32'h180, no_ex(), pc_plus4, 0, 0, 32'h184, 32'h0);
    // EX redirect wins over IF taken prediction
    step(0, 32'h100, mk_br(32'h44, 0, 32'h90, 1, 32'h90, 0), br_en, 1, 1, 32'h140, 32'h48);
    // JAL allocation as unconditional, predicted taken even with weak BHT
    step(0, 32'h60, mk_jal(32'h200, 32'h80, 0, 32'h204), alu_out, 1, 0, 32'h64, 32'h204);
    step(0, 32'h200, no_ex(), br_predict, 0, 1, 32'h80, 32'h0);
    step(0, 32'h100, mk_br(32'h100, 0, 32'h140, 0, 32'h104, 0), pc_plus4, 0, 0, 32'h104, 32'h104);
    step(0, 32'h100, mk_br(32'h100, 0, 32'h140, 0, 32'h104, 0), pc_plus4, 0, 0, 32'h104, 32'h104);
    step(0, 32'h200, no_ex(), br_predict, 0, 1, 32'h80, 32'h0);
    step(0, 32'h200, mk_jal(32'h200, 32'h80, 1, 32'h80), br_predict, 0, 1, 32'h80, 32'h204);
    // stalled JALR and stalled taken branch: no redirect, no training
    step(0, 32'h200, mk_jalr(32'h34, 32'h88, 1), br_predict, 0, 1, 32'h80, 32'h0);
    step(0, 32'h60, mk_br(32'h60, 1, 32'h20, 0, 32'h64, 1), pc_plus4, 0, 0, 32'h64, 32'h0);
    step(0, 32'h60, no_ex(), pc_plus4, 0, 0, 32'h64, 32'h0);
    step(0, 32'h200, mk_jalr(32'h34, 32'h88, 0), alu_mod2, 1, 1, 32'h80, 32'h38);
    step(0, 32'h34, no_ex(), pc_plus4, 0, 0, 32'h38, 32'h0);
    // invalid EX slot is ignored
    tmp = mk_br(32'h60, 1, 32'h20, 0, 32'h64, 0);
    tmp.valid = 1'b0;
    step(0, 32'h60, tmp, pc_plus4, 0, 0, 32'h64, 32'h0);
    step(0, 32'h60, no_ex(), pc_plus4, 0, 0, 32'h64, 32'h0);
    // reset mid-operation beats training and clears the BTB
    step(1, 32'h200, mk_br(32'h60, 1, 32'h20, 0, 32'h64, 0), pc_plus4, 0, 0, 32'h0, 32'h0);
    step(0, 32'h200, no_ex(), pc_plus4, 0, 0, 32'h204, 32'h0);
    step(0, 32'h60, no_ex(), pc_plus4, 0, 0, 32'h64, 32'h0);

    @(negedge clk);
    #1;
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
